// File: rtl/thirtytwo_bit_xor.sv
// thirtytwo_bit_xor: per-bit combinational XOR with a registered result, zero and parity flags
module thirtytwo_bit_xor #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             VALID_I,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_R,
   output logic             VALID_O,
   output logic             ZERO,
   output logic             PARITY
);
   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_cell
         assign Y[i] = A[i] ^ B[i];
      end
   endgenerate
   // capture the XOR result and its flags; flags and result hold when nothing is captured
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Y_R     <= '0;
         VALID_O <= 1'b0;
         ZERO    <= 1'b1;
         PARITY  <= 1'b0;
      end else begin
         VALID_O <= VALID_I;
         if (VALID_I) begin
            Y_R    <= Y;
            ZERO   <= ~|Y;
            PARITY <= ^Y;
         end
      end
   end
endmodule

// File: tb/tb_thirtytwo_bit_xor.sv
// tb_thirtytwo_bit_xor: table-driven and randomized checks of thirtytwo_bit_xor
module tb_thirtytwo_bit_xor;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        VALID_I = 1'b0;
   logic [31:0] Y, Y_R;
   logic        VALID_O, ZERO, PARITY;
   int          errors = 0;
   int          checks = 0;

   thirtytwo_bit_xor #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .VALID_I(VALID_I),
      .Y(Y), .Y_R(Y_R), .VALID_O(VALID_O), .ZERO(ZERO), .PARITY(PARITY)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic        zero;
      logic        parity;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t        tbl[8];
      logic [31:0] m_y;
      logic        m_v, m_z, m_p;
      tbl[0] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
      tbl[1] = '{32'h000000F0, 32'h000000FF, 32'h0000000F, 1'b0, 1'b0};
      tbl[2] = '{32'h0000000F, 32'h000000FF, 32'h000000F0, 1'b0, 1'b0};
      tbl[3] = '{32'h000000FF, 32'h000000AA, 32'h00000055, 1'b0, 1'b0};
      tbl[4] = '{32'hA5A5A5A5, 32'h00000000, 32'hA5A5A5A5, 1'b0, 1'b0};
      tbl[5] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0};
      tbl[6] = '{32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 1'b0, 1'b1};
      tbl[7] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b1};

      // reset state, Y live during reset
      A = 32'h0F0F0000;
      B = 32'h00FF00FF;
      VALID_I = 1'b1;
      tick();
      chk("rst_y_r", Y_R, 32'h0);
      chk("rst_valid_o", {31'b0, VALID_O}, 32'h0);
      chk("rst_zero", {31'b0, ZERO}, 32'h1);
      chk("rst_parity", {31'b0, PARITY}, 32'h0);
      chk("rst_y", Y, 32'h0FF000FF);
      VALID_I = 1'b0;
      rst = 1'b0;
      tick();
      chk("idle_valid_o", {31'b0, VALID_O}, 32'h0);

      // directed vectors
      for (int k = 0; k < 8; k++) begin
         A = tbl[k].a;
         B = tbl[k].b;
         VALID_I = 1'b1;
         #1;
         chk($sformatf("tbl%0d_y", k), Y, tbl[k].y);
         tick();
         chk($sformatf("tbl%0d_y_r", k), Y_R, tbl[k].y);
         chk($sformatf("tbl%0d_zero", k), {31'b0, ZERO}, {31'b0, tbl[k].zero});
         chk($sformatf("tbl%0d_parity", k), {31'b0, PARITY}, {31'b0, tbl[k].parity});
         chk($sformatf("tbl%0d_valid_o", k), {31'b0, VALID_O}, 32'h1);
      end

      // hold after VALID_I drops
      VALID_I = 1'b0;
      A = 32'h11111111;
      B = 32'h22222222;
      tick();
      chk("hold_valid_o", {31'b0, VALID_O}, 32'h0);
      chk("hold_y_r", Y_R, 32'hFFFFFFFE);
      chk("hold_parity", {31'b0, PARITY}, 32'h1);
      chk("hold_zero", {31'b0, ZERO}, 32'h0);

      // randomized against a one-cycle-delayed reference
      m_y = 32'hFFFFFFFE;
      m_z = 1'b0;
      m_p = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         A = $urandom;
         B = (n % 50 == 0) ? A : $urandom;
         VALID_I = 1'($urandom_range(0, 1));
         #1;
         chk("rnd_y", Y, A ^ B);
         m_v = VALID_I;
         if (VALID_I) begin
            m_y = A ^ B;
            m_z = (m_y == 0);
            m_p = ($countones(m_y) % 2) == 1;
         end
         tick();
         chk("rnd_y_r", Y_R, m_y);
         chk("rnd_zero", {31'b0, ZERO}, {31'b0, m_z});
         chk("rnd_parity", {31'b0, PARITY}, {31'b0, m_p});
         chk("rnd_valid_o", {31'b0, VALID_O}, {31'b0, m_v});
      end

      // asynchronous reset between edges discards the capture
      A = 32'h12345678;
      B = 32'h0;
      VALID_I = 1'b1;
      tick();
      chk("pre_rst_y_r", Y_R, 32'h12345678);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_y_r", Y_R, 32'h0);
      chk("arst_valid_o", {31'b0, VALID_O}, 32'h0);
      chk("arst_zero", {31'b0, ZERO}, 32'h1);
      chk("arst_parity", {31'b0, PARITY}, 32'h0);
      chk("arst_y", Y, 32'h12345678);
      tick();
      chk("rst_ignores_valid", Y_R, 32'h0);
      chk("rst_ignores_valid_o", {31'b0, VALID_O}, 32'h0);
      #2;
      rst = 1'b0;
      A = 32'h80000001;
      B = 32'h00000003;
      tick();
      chk("post_rst_y_r", Y_R, 32'h80000002);
      chk("post_rst_valid_o", {31'b0, VALID_O}, 32'h1);
      chk("post_rst_parity", {31'b0, PARITY}, 32'h0);
      chk("post_rst_zero", {31'b0, ZERO}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/thirtytwo_bit_xor.md
THIRTYTWO_BIT_XOR -- requirements
Module: thirtytwo_bit_xor

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; only 32 is required to be supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: Y  output  WIDTH  combinational bitwise XOR of A and B.
REQ-005 Port: A  input  WIDTH  operand A.
REQ-006 Port: B  input  WIDTH  operand B.
REQ-007 Port: VALID_I  input  1  operands on A/B are to be captured this cycle.
REQ-008 Port: Y_R  output  WIDTH  registered XOR result.
REQ-009 Port: VALID_O  output  1  Y_R/ZERO/PARITY hold a newly captured result.
REQ-010 Port: ZERO  output  1  registered flag, 1 when captured result is all zeros.
REQ-011 Port: PARITY  output  1  registered flag, XOR-reduction of captured result (1 = odd number of ones).

Function
REQ-012 Y SHALL equal A XOR B bit-for-bit at all times, purely combinational, zero-cycle latency, independent of clk and rst.
REQ-013 Y SHALL be built from WIDTH independent 1-bit XOR cells, one per bit position i, Y[i] = A[i] XOR B[i]; no bit depends on any other bit.
REQ-014 Y SHALL have no unknown bits when A and B are fully known.
REQ-015 On a rising clk edge with VALID_I=1 and rst=0, Y_R SHALL load A XOR B; latency 1 cycle.
REQ-016 On the same edge, ZERO SHALL load 1 if A XOR B = 0, else 0.
REQ-017 On the same edge, PARITY SHALL load the XOR of all WIDTH bits of A XOR B.
REQ-018 On the same edge, VALID_O SHALL go to 1.
REQ-019 On a rising edge with VALID_I=0 and rst=0, Y_R, ZERO and PARITY SHALL hold their values and VALID_O SHALL go to 0.
REQ-020 Back-to-back VALID_I=1 cycles SHALL each produce a result one cycle later; throughput one result per cycle, no stalls, no backpressure.
REQ-021 Operands SHALL be treated as unsigned bit vectors; no carry, overflow or sign handling.
REQ-022 Identity rules SHALL hold for every value: A XOR 0 = A; A XOR A = 0; A XOR all-ones = NOT A.

Reset
REQ-023 While rst=1, Y_R SHALL be 0, VALID_O 0, ZERO 1, PARITY 0, asynchronously, without waiting for a clk edge.
REQ-024 rst asserted mid-operation SHALL discard any in-flight capture; VALID_I is ignored while rst=1.
REQ-025 After rst deasserts, the first rising edge with VALID_I=1 SHALL capture normally.
REQ-026 rst SHALL NOT affect Y, which continues to track A XOR B during reset.

Verification
REQ-027 A=0x00000000, B=0x00000000 -> Y=0x00000000 immediately; after capture Y_R=0, ZERO=1, PARITY=0, VALID_O=1.
REQ-028 A=0x000000F0, B=0x000000FF -> Y=0x0000000F with no clock; after capture Y_R=0x0000000F, ZERO=0, PARITY=0.
REQ-029 A=0x0000000F, B=0x000000FF -> Y=0x000000F0; A=0x000000FF, B=0x000000AA -> Y=0x00000055, PARITY=0 after capture.
REQ-030 A=0xFFFFFFFF, B=0x00000001 with VALID_I=1 -> next edge Y_R=0xFFFFFFFE, PARITY=1, ZERO=0; next edge with VALID_I=0 -> VALID_O=0, Y_R held.
REQ-031 Capture A=0x12345678, B=0x0, then assert rst between clock edges -> Y_R=0, VALID_O=0, ZERO=1 immediately, while Y stays 0x12345678.
REQ-032 Random A/B for at least 1000 cycles with random VALID_I -> Y always equals A XOR B; Y_R/ZERO/PARITY match a one-cycle-delayed model.
